// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch program counter.
// Contents: next-PC select enum, default address width, reset vectors
// for fetch and for the testbench.
package pc_pkg;

    localparam int unsigned PC_ADDR_W = 16;

    localparam logic [PC_ADDR_W-1:0] PC_RESET_VEC    = 16'h0000;
    localparam logic [PC_ADDR_W-1:0] PC_TB_RESET_VEC = 16'h0100;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_REDIR = 3'd1,
        SEL_RET   = 3'd2,
        SEL_CALL  = 3'd3,
        SEL_SEQ   = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: fetch-control bundle between IF control and the PC sequencer.
// master: drives hlt/stall/redirect/redirect_pc/call/call_target/ret,
//         observes iaddr/pc_plus_1/halted/ras_* status.
// slave : the PC sequencer (pc_seq).
interface pc_seq_if import pc_pkg::*; #(
    parameter int unsigned ADDR_W = PC_ADDR_W
) ();
    logic              hlt;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              call;
    logic [ADDR_W-1:0] call_target;
    logic              ret;
    logic [ADDR_W-1:0] iaddr;
    logic [ADDR_W-1:0] pc_plus_1;
    logic              halted;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;
    logic              ras_unf;

    modport master (
        output hlt, stall, redirect, redirect_pc, call, call_target, ret,
        input  iaddr, pc_plus_1, halted, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  hlt, stall, redirect, redirect_pc, call, call_target, ret,
        output iaddr, pc_plus_1, halted, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_seq_ras_stack.sv
// ras_stack: circular return-address stack with saturating occupancy count.
// Ports: clk, rst (async, active-high), push/push_data, pop, top (current
// top entry), empty/full (decoded from registered count), ovf (sticky,
// set by a push while full). A push while full overwrites the oldest entry.
module ras_stack import pc_pkg::*; #(
    parameter int unsigned ADDR_W    = PC_ADDR_W,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ovf   = ovf_q;
    // wp points at the next free slot; the top lives one below it (mod depth)
    assign top   = mem_q[wp_q - PTR_W'(1)];

    // Pointer/count update; push and pop never coincide at the caller
    always_comb begin
        wp_d  = wp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push) begin
            wp_d = wp_q + PTR_W'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wp_d  = wp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Entry storage carries no reset; contents are meaningless until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= push_data;
        end
    end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: fetch program counter with priority next-PC select
// (halt > redirect > stall > ret > call > sequential) and optional RAS.
// Ports: clk, rst (async, active-high), bus (pc_seq_if.slave): control
// inputs hlt/stall/redirect/redirect_pc/call/call_target/ret; outputs
// iaddr (registered), pc_plus_1 (combinational), halted, ras_empty,
// ras_full, ras_ovf, ras_unf (one-cycle registered pulse).
// Build option: define PC_RAS_EN to build the return-address stack;
// without it ret falls through to pc_plus_1 and always pulses ras_unf.
module pc_seq import pc_pkg::*; #(
    parameter int unsigned       ADDR_W    = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_seq_if.slave  bus
);
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_seq: RAS_DEPTH must be a power of two and at least 2");
    end

    pc_sel_e           sel;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d;
    logic [ADDR_W-1:0] pc_plus_1;
    logic              halted_q, halted_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty, ras_full, ras_ovf;

    assign pc_plus_1 = iaddr_q + ADDR_W'(1);

`ifdef PC_RAS_EN
    logic ras_push, ras_pop;
    // A ret with an empty stack is a no-op pop inside ras_stack
    assign ras_push = (sel == SEL_CALL);
    assign ras_pop  = (sel == SEL_RET);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus_1),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf)
    );
`else
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_ovf   = 1'b0;
`endif

    // Next-PC select and next-state, first match wins
    always_comb begin
        sel      = SEL_SEQ;
        iaddr_d  = pc_plus_1;
        halted_d = halted_q;
        unf_d    = 1'b0;

        if (halted_q || bus.hlt) begin
            sel      = SEL_HOLD;
            halted_d = 1'b1;
        end else if (bus.redirect) begin
            sel = SEL_REDIR;
        end else if (bus.stall) begin
            sel = SEL_HOLD;
        end else if (bus.ret) begin
            sel = SEL_RET;
        end else if (bus.call) begin
            sel = SEL_CALL;
        end

        unique case (sel)
            SEL_HOLD:  iaddr_d = iaddr_q;
            SEL_REDIR: iaddr_d = bus.redirect_pc;
            SEL_RET: begin
                iaddr_d = ras_empty ? pc_plus_1 : ras_top;
                unf_d   = ras_empty;
            end
            SEL_CALL:  iaddr_d = bus.call_target;
            default:   iaddr_d = pc_plus_1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iaddr_q  <= RESET_VEC;
            halted_q <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            iaddr_q  <= iaddr_d;
            halted_q <= halted_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.iaddr     = iaddr_q;
    assign bus.pc_plus_1 = pc_plus_1;
    assign bus.halted    = halted_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_ovf   = ras_ovf;
    assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed self-checking bench for pc_seq (RESET_VEC=0x0100,
// RAS_DEPTH=4). Expected values track the PC_RAS_EN build option.
module tb_pc_seq;
    import pc_pkg::*;

    localparam int unsigned AW = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    pc_seq_if #(.ADDR_W(AW)) bus_if ();

    pc_seq #(
        .ADDR_W    (AW),
        .RESET_VEC (PC_TB_RESET_VEC),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.hlt         = 1'b0;
        bus_if.stall       = 1'b0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = '0;
        bus_if.call        = 1'b0;
        bus_if.call_target = '0;
        bus_if.ret         = 1'b0;
    endtask

    task automatic jump(input logic [AW-1:0] pc);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = pc;
        tick();
        bus_if.redirect    = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic [AW-1:0] exp_pc;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle();
        rst = 1'b1;
        #1;
        // Reset state, observed before any clock edge
        check_eq("rst_iaddr",     bus_if.iaddr,     32'h0100);
        check_eq("rst_pc_plus_1", bus_if.pc_plus_1, 32'h0101);
        check_eq("rst_halted",    bus_if.halted,    0);
        check_eq("rst_empty",     bus_if.ras_empty, 1);
        check_eq("rst_full",      bus_if.ras_full,  0);
        check_eq("rst_ovf",       bus_if.ras_ovf,   0);
        check_eq("rst_unf",       bus_if.ras_unf,   0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("seq_0", bus_if.iaddr, 32'h0100);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq($sformatf("seq_%0d", i), bus_if.iaddr, 32'h0100 + i);
        end
        check_eq("seq_empty", bus_if.ras_empty, 1);

        // Priority: redirect beats stall and call
        jump(16'h0010);
        check_eq("prio_setup", bus_if.iaddr, 32'h0010);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 16'h0400;
        bus_if.stall       = 1'b1;
        bus_if.call        = 1'b1;
        bus_if.call_target = 16'h0777;
        tick();
        idle();
        check_eq("prio_iaddr", bus_if.iaddr,     32'h0400);
        check_eq("prio_nopush", bus_if.ras_empty, 1);
        // Stall alone holds
        bus_if.stall = 1'b1;
        tick();
        idle();
        check_eq("stall_hold", bus_if.iaddr, 32'h0400);

        // Call and return
        jump(16'h0020);
        bus_if.call        = 1'b1;
        bus_if.call_target = 16'h0300;
        tick();
        idle();
        check_eq("call_iaddr", bus_if.iaddr,     32'h0300);
        check_eq("call_empty", bus_if.ras_empty, RAS_ON ? 0 : 1);
        for (int i = 0; i < 5; i++) tick();
        check_eq("call_seq5", bus_if.iaddr, 32'h0305);
        bus_if.ret = 1'b1;
        tick();
        idle();
        check_eq("ret_iaddr", bus_if.iaddr,     RAS_ON ? 32'h0021 : 32'h0306);
        check_eq("ret_unf",   bus_if.ras_unf,   RAS_ON ? 0 : 1);
        check_eq("ret_empty", bus_if.ras_empty, 1);
        tick();
        check_eq("ret_unf_clr", bus_if.ras_unf, 0);

        // Overflow: five nested calls, each to the next address
        jump(16'h0010);
        for (int i = 0; i < 5; i++) begin
            bus_if.call        = 1'b1;
            bus_if.call_target = 16'h0011 + 16'(i);
            tick();
            check_eq($sformatf("ovf_call%0d", i), bus_if.iaddr, 32'h0011 + i);
            if (i == 3) begin
                check_eq("ovf_full4", bus_if.ras_full, RAS_ON ? 1 : 0);
                check_eq("ovf_pre",   bus_if.ras_ovf,  0);
            end
        end
        idle();
        check_eq("ovf_set",  bus_if.ras_ovf,  RAS_ON ? 1 : 0);
        check_eq("ovf_full", bus_if.ras_full, RAS_ON ? 1 : 0);

        // Underflow: five returns; the oldest entry was overwritten
        exp_pc = 16'h0015;
        for (int i = 0; i < 5; i++) begin
            bus_if.ret = 1'b1;
            tick();
            if (RAS_ON) begin
                exp_pc = (i < 4) ? 16'h0015 - 16'(i) : 16'h0013;
                check_eq($sformatf("unf_ret%0d", i), bus_if.iaddr, {16'h0, exp_pc});
                check_eq($sformatf("unf_pulse%0d", i), bus_if.ras_unf, (i == 4) ? 1 : 0);
            end else begin
                check_eq($sformatf("unf_ret%0d", i), bus_if.iaddr, 32'h0016 + i);
                check_eq($sformatf("unf_pulse%0d", i), bus_if.ras_unf, 1);
            end
        end
        idle();
        tick();
        check_eq("unf_clr",   bus_if.ras_unf,   0);
        check_eq("unf_empty", bus_if.ras_empty, 1);
        check_eq("ovf_stick", bus_if.ras_ovf,   RAS_ON ? 1 : 0);

        // Halt is sticky and dominates everything
        jump(16'h0050);
        bus_if.hlt = 1'b1;
        tick();
        idle();
        check_eq("hlt_iaddr",  bus_if.iaddr,  32'h0050);
        check_eq("hlt_halted", bus_if.halted, 1);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 16'h0600;
        bus_if.call        = 1'b1;
        bus_if.call_target = 16'h0700;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("hlt_hold%0d", i), bus_if.iaddr, 32'h0050);
        end
        check_eq("hlt_nopush", bus_if.ras_empty, 1);
        check_eq("hlt_still",  bus_if.halted,    1);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check_eq("hlt_rst_iaddr",  bus_if.iaddr,   32'h0100);
        check_eq("hlt_rst_halted", bus_if.halted,  0);
        check_eq("hlt_rst_ovf",    bus_if.ras_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("post_rst_seq", bus_if.iaddr, 32'h0101);

        // Wrap at all-ones
        jump(16'hFFFF);
        check_eq("wrap_p1", bus_if.pc_plus_1, 32'h0000);
        tick();
        check_eq("wrap_iaddr", bus_if.iaddr, 32'h0000);
        tick();
        check_eq("wrap_seq", bus_if.iaddr, 32'h0001);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst", bus_if.iaddr, 32'h0100);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("async_hold", bus_if.iaddr, 32'h0100);
        tick();
        check_eq("async_seq", bus_if.iaddr, 32'h0101);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    // Safety net against an unexpected stall of the stimulus thread
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
